// File: rtl/aes_shiftrows_pipe.sv
// Elastic multi-lane AES ShiftRows / InvShiftRows engine with valid/ready on both sides.
// The transform is registered into stage 0; later stages are skid-free elastic registers.
module aes_shiftrows_pipe #(
  parameter int LANES  = 1,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_inv,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic [128*LANES-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_inv,
  output logic [TAG_W-1:0]       out_tag,
  output logic [128*LANES-1:0]   out_data,
  output logic                   busy
);

  localparam int DW = 128 * LANES;

  // Byte i = 4c + r sits at bits [127-8i -: 8]; the source column wraps via 2-bit truncation.
  function automatic logic [127:0] f_shift(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [1:0]   sc;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sc = inv ? 2'(c - r) : 2'(c + r);
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * int'(sc) + r) -: 8];
      end
    end
    return o;
  endfunction

  logic [DW-1:0]     w_xform;
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_inv;
  logic [TAG_W-1:0]  r_tag  [STAGES];
  logic [DW-1:0]     r_data [STAGES];

  always_comb begin
    w_xform = '0;
    for (int k = 0; k < LANES; k++) begin
      w_xform[128 * k +: 128] = f_shift(in_data[128 * k +: 128], in_inv);
    end
  end

  // A stage can load whenever any stage from it to the output is empty or the output drains.
  always_comb begin
    w_load = '0;
    for (int s = 0; s < STAGES; s++) begin
      w_load[s] = out_ready;
      for (int t = s; t < STAGES; t++) begin
        if (!r_vld[t]) w_load[s] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_inv <= '0;
      for (int s = 0; s < STAGES; s++) begin
        r_tag[s]  <= '0;
        r_data[s] <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_vld[0] <= in_valid;
        if (in_valid) begin
          r_inv[0]  <= in_inv;
          r_tag[0]  <= in_tag;
          r_data[0] <= w_xform;
        end
      end
      for (int s = 1; s < STAGES; s++) begin
        if (w_load[s]) begin
          r_vld[s] <= r_vld[s-1];
          if (r_vld[s-1]) begin
            r_inv[s]  <= r_inv[s-1];
            r_tag[s]  <= r_tag[s-1];
            r_data[s] <= r_data[s-1];
          end
        end
      end
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_vld[STAGES-1];
  assign out_inv   = r_inv[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];
  assign out_data  = r_data[STAGES-1];
  assign busy      = |r_vld;

endmodule

// File: doc/aes_shiftrows_pipe.md
Name: aes_shiftrows_pipe

Overview:
- Elastic, pipelined ShiftRows engine for the AES-128 datapath. Each beat carries LANES independent 128-bit states.
- Each beat selects forward ShiftRows (encrypt) or InvShiftRows (decrypt).
- Uses valid/ready handshakes on both sides and carries a sideband tag, so round-pipeline control can track blocks through the engine.
- Sits between SubBytes/InvSubBytes and MixColumns/AddRoundKey in the round datapath.

Parameters:
- LANES, 1, number of 128-bit states processed per beat (1..8).
- STAGES, 2, register stages from input to output (1..4); this is the latency.
- TAG_W, 4, width of the opaque sideband tag carried with each beat (>=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine can accept a beat this cycle.
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows for this beat.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- in_data  in  128*LANES  lane k occupies bits [128k+127:128k].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_inv  out  1  mode bit of the output beat.
- out_tag  out  TAG_W  tag of the output beat.
- out_data  out  128*LANES  transformed states.
- busy  out  1  OR of all stage valid bits.

Behaviour:
- Byte map, per lane:
  - Byte i = bits [127-8i:120-8i], with i = 4c + r (column-major, r = row, c = column).
  - Forward: out(r,c) = in(r,(c+r) mod 4).
  - Inverse: out(r,c) = in(r,(c-r) mod 4).
  - Row 0 is never moved. All lanes use the same in_inv.
- Transform is combinational on in_data and is registered into stage 0. Stages 1..STAGES-1 are plain registers holding {valid, inv, tag, data}. Output ports are driven directly from the last stage.
- Stage advance:
  - Stage s loads when it is empty, or when its content leaves this cycle.
  - Stage s's content leaves when s+1 loads, or, for the last stage, when out_valid && out_ready.
- in_ready = stage 0 loads (combinational from out_ready back through the chain).
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Throughput and latency:
  - Full throughput (one beat/cycle) while out_ready = 1.
  - Latency is exactly STAGES cycles from input transfer to out_valid.
  - No bubbles are inserted. Empty stages ahead of a stall are filled (bubble collapse).
- Backpressure:
  - While out_ready = 0, out_valid, out_data, out_tag and out_inv stay stable.
  - Upstream stages fill. in_ready drops once all STAGES stages are valid and out_ready = 0.
  - Capacity is STAGES beats. No beat is ever dropped or duplicated.
- Simultaneous events: with a full pipe and out_ready = 1, an output transfer and an input transfer happen in the same cycle.
- Mode switching: in_inv may change every beat. Mixed-mode beats in flight are each transformed by their own mode bit.
- in_data, in_tag and in_inv are ignored when in_valid = 0.
- Reset:
  - rst_n low clears, asynchronously, all stage valids, data, tag and inv registers to 0.
  - Resulting values: out_valid = 0, out_data = 0, out_tag = 0, out_inv = 0, busy = 0, in_ready = 1.
  - Reset mid-operation discards all in-flight beats. The first beat after deassertion follows normal latency.
- Reset release is synchronised externally. The engine has no other flush mechanism.

Test Plan:
- LANES=1, STAGES=2, forward: in_data = 00112233445566778899AABBCCDDEEFF, in_tag = 3 -> two cycles later out_data = 0055AAFF4499EE3388DD2277CC1166BB, out_tag = 3, out_inv = 0.
- Inverse, same input, in_inv = 1 -> out_data = 00DDAA774411EEBB885522FFCC996633. Feeding the forward result back with in_inv = 1 returns 00112233445566778899AABBCCDDEEFF.
- LANES=2: lane0 = the vector above, lane1 = 000102030405060708090A0B0C0D0E0F, forward -> lane1 output 00050A0F04090E03080D02070C01060B, lane0 output as in the first scenario.
- Stream of 8 beats, alternating inv, tags 0..7, with out_ready held low for cycles 3..6:
  - in_ready = 0 once STAGES beats are held.
  - Outputs stay stable while stalled.
  - All 8 beats emerge in order with correct per-beat mode and no loss.
- Continuous valid with out_ready = 1 -> one output per cycle after STAGES cycles, and in_ready stays high throughout.
- Assert rst_n low with 2 beats in flight -> out_valid, busy and out_data go to 0 immediately (asynchronously). After release, a new beat appears after exactly STAGES cycles.
